// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
// Program counter plus instruction-fetch sequencer sitting in front of decode.
// One instruction-memory request is outstanding at most; the returned word is
// parked in a single output register until decode takes it. An ALU redirect
// reloads the PC, flushes the output register and drops any in-flight response.
module fetch_pc_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic            pc_input_sel,
    input  logic [XLEN-1:0] alu_result,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_misalign
);

    localparam logic            PC_INPUT_ALU = 1'b1;
    localparam logic [XLEN-1:0] PC_STEP      = {{(XLEN-3){1'b0}}, 3'd4};

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   pc_s;
    logic              discard_r;
    logic              discard_s;
    logic              run_r;
    logic              instr_valid_r;
    logic              instr_valid_s;
    logic [31:0]       instr_r;
    logic [31:0]       instr_s;
    logic [XLEN-1:0]   instr_pc_r;
    logic [XLEN-1:0]   instr_pc_s;
    logic              misalign_r;
    logic              misalign_s;

    logic [XLEN-1:0]   target_s;
    logic              redirect_alu_s;
    logic              redirect_ok_s;
    logic              redirect_bad_s;
    logic              out_free_s;
    logic              req_valid_s;
    logic              req_fire_s;

    // Redirect decode: bit 0 of the target is always cleared (JALR semantics),
    // bit 1 left set means the target is not word aligned.
    assign target_s       = {alu_result[XLEN-1:1], 1'b0};
    assign redirect_alu_s = redirect_valid & (pc_input_sel == PC_INPUT_ALU);
    assign redirect_ok_s  = redirect_alu_s & (target_s[1] == 1'b0);
    assign redirect_bad_s = redirect_alu_s & (target_s[1] == 1'b1);

    // A request is only offered when its response will have somewhere to land;
    // run_r holds requests off until the first edge after reset release.
    assign out_free_s  = ~instr_valid_r | instr_ready;
    assign req_valid_s = run_r & (state_r == ST_FETCH) & out_free_s;
    assign req_fire_s  = req_valid_s & imem_req_ready;

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign instr_valid    = instr_valid_r;
    assign instr          = instr_r;
    assign instr_pc       = instr_pc_r;
    assign fetch_misalign = misalign_r;

    // Next-state for the fetch sequencer, PC, discard flag and output register.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        discard_s     = discard_r;
        instr_valid_s = instr_valid_r & ~instr_ready;
        instr_s       = instr_r;
        instr_pc_s    = instr_pc_r;
        misalign_s    = 1'b0;

        case (state_r)
            ST_FETCH: begin
                if (req_fire_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_s = ST_FETCH;
                    if (discard_r) begin
                        discard_s = 1'b0;
                    end else begin
                        instr_s       = imem_rsp_data;
                        instr_pc_s    = pc_r;
                        instr_valid_s = 1'b1;
                        pc_s          = pc_r + PC_STEP;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase

        // Redirect overrides everything above. A response landing in the same
        // cycle is simply not loaded; one still in flight is marked for discard.
        if (redirect_ok_s) begin
            pc_s          = target_s;
            instr_valid_s = 1'b0;
            instr_s       = instr_r;
            instr_pc_s    = instr_pc_r;
            if (state_r == ST_WAIT) begin
                if (imem_rsp_valid) begin
                    discard_s = 1'b0;
                end else begin
                    discard_s = 1'b1;
                end
            end else if (req_fire_s) begin
                discard_s = 1'b1;
            end else begin
                discard_s = discard_r;
            end
        end else if (redirect_bad_s) begin
            misalign_s = 1'b1;
        end else begin
            misalign_s = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            discard_r     <= 1'b0;
            run_r         <= 1'b0;
            instr_valid_r <= 1'b0;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= {XLEN{1'b0}};
            misalign_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            discard_r     <= discard_s;
            run_r         <= 1'b1;
            instr_valid_r <= instr_valid_s;
            instr_r       <= instr_s;
            instr_pc_r    <= instr_pc_s;
            misalign_r    <= misalign_s;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: randomized imem/decode/redirect stimulus,
// transaction-level reference model, scoreboard queue drained by a monitor.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        redirect_valid;
    logic        pc_input_sel;
    logic [31:0] alu_result;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misalign;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .pc_input_sel   (pc_input_sel),
        .alu_result     (alu_result),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;

    // reference model state (transaction level)
    logic [31:0] exp_pc     = 32'h0000_0000;
    logic        outstanding = 1'b0;
    logic        out_cancel  = 1'b0;
    logic [31:0] out_addr    = 32'h0000_0000;
    int          rsp_cnt     = 0;
    logic        mis_exp     = 1'b0;

    // stimulus knobs
    int          rdy_pct     = 100;
    int          req_rdy_pct = 100;
    int          dmax        = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] rand_target();
        return (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        exp_pc      = 32'h0000_0000;
        outstanding = 1'b0;
        out_cancel  = 1'b0;
        rsp_cnt     = 0;
        mis_exp     = 1'b0;
        sb_q.delete();
    endtask

    // mode: 0 random redirects, 1 forced ALU redirect to tgt,
    //       2 forced PC+4 redirect, 3 no redirect
    task automatic step(input int mode, input logic [31:0] tgt);
        logic        exp_req;
        logic        red_ok;
        logic        red_bad;
        logic        accept;
        logic [31:0] tmask;
        @(negedge clk);
        instr_ready    = ($urandom_range(0, 99) < rdy_pct);
        imem_req_ready = ($urandom_range(0, 99) < req_rdy_pct);
        case (mode)
            0: begin
                redirect_valid = ($urandom_range(0, 99) < 12);
                pc_input_sel   = 1'($urandom_range(0, 1));
                alu_result     = rand_target();
            end
            1: begin
                redirect_valid = 1'b1;
                pc_input_sel   = 1'b1;
                alu_result     = tgt;
            end
            2: begin
                redirect_valid = 1'b1;
                pc_input_sel   = 1'b0;
                alu_result     = rand_target();
            end
            default: begin
                redirect_valid = 1'b0;
                pc_input_sel   = 1'($urandom_range(0, 1));
                alu_result     = rand_target();
            end
        endcase
        if (outstanding) rsp_cnt--;
        if (outstanding && rsp_cnt <= 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(out_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #2;
        tmask   = alu_result & 32'hFFFF_FFFE;
        red_ok  = redirect_valid && pc_input_sel && (tmask[1:0] == 2'b00);
        red_bad = redirect_valid && pc_input_sel && (tmask[1:0] != 2'b00);
        exp_req = !outstanding && (sb_q.size() == 0 || instr_ready);
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        accept = imem_req_valid && imem_req_ready;
        if (imem_rsp_valid) begin
            if (!out_cancel && !red_ok) begin
                sb_q.push_back('{pc: out_addr, word: mem_word(out_addr)});
                exp_pc = out_addr + 32'd4;
            end
            outstanding = 1'b0;
        end
        if (accept) begin
            check("req_addr", imem_req_addr, exp_pc);
            n_acc++;
            outstanding = 1'b1;
            out_addr    = exp_pc;
            out_cancel  = 1'b0;
            rsp_cnt     = int'($urandom_range(1, dmax));
        end
        if (red_ok) begin
            exp_pc     = tmask;
            out_cancel = 1'b1;
            sb_q.delete();
        end
        mis_exp = red_bad;
    endtask

    // Monitor: checks the output register against the scoreboard every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            check("instr_valid", 32'(instr_valid), 32'(sb_q.size() != 0));
            check("misalign", 32'(fetch_misalign), 32'(mis_exp));
            if (instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_instr", 32'(instr_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("instr", instr, e.word);
                    check("instr_pc", instr_pc, e.pc);
                end
            end
        end
    end

    task automatic check_outputs_zero();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
    endtask

    task automatic wait_outstanding(input string name);
        int k;
        k = 0;
        while (!outstanding && k < 20) begin
            step(3, 32'd0);
            k++;
        end
        if (!outstanding) check(name, 32'd0, 32'd1);
    endtask

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        pc_input_sel   = 1'b0;
        alu_result     = 32'd0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        instr_ready    = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero();
        reset_n = 1'b1;
        #1;
        check("first_req_delay", 32'(imem_req_valid), 32'd0);

        // sequential stream, 1-cycle responses: one request every 2 cycles
        n_acc = 0;
        repeat (12) step(3, 32'd0);
        check("req_rate", 32'(n_acc), 32'd6);

        // decode stall holds the instruction and withholds requests
        rdy_pct = 0;
        repeat (6) step(3, 32'd0);
        rdy_pct = 100;
        repeat (4) step(3, 32'd0);

        // aligned redirect while a response is pending
        dmax = 3;
        wait_outstanding("reach_wait_a");
        step(1, 32'h0000_0100);
        repeat (8) step(3, 32'd0);

        // JALR-style odd target that lands misaligned
        step(1, 32'h0000_0203);
        repeat (4) step(3, 32'd0);

        // PC+4 redirect leaves the stream alone
        step(2, 32'd0);
        repeat (6) step(3, 32'd0);

        // randomized mix
        rdy_pct     = 70;
        req_rdy_pct = 75;
        repeat (400) step(0, 32'd0);

        // asynchronous reset in the middle of a pending fetch
        rdy_pct     = 100;
        req_rdy_pct = 100;
        wait_outstanding("reach_wait_b");
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check_outputs_zero();
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rerelease_req", 32'(imem_req_valid), 32'd0);

        rdy_pct     = 80;
        req_rdy_pct = 80;
        repeat (200) step(0, 32'd0);

        rdy_pct = 100;
        repeat (8) step(3, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
